rob_commit: RTL and testbench

- Reorder buffer and in-order commit unit.
- Receives out-of-order completions tagged by ROB pointer from the EXE stage (ALU/branch results) and from the load/store unit (load data).
- Retires entries strictly in program order, one per cycle.
- Drives the commit-stage forwarding buses (fwd_*_1_COM, LS_fwd_*_COM) back into EXE, and issues the branch redirect/flush.

---
 rtl/rob_commit.sv | 204 ++++++++++++++++++++
 tb/tb_rob_commit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - reorder buffer with out-of-order completion and in-order single-retire commit
module rob_commit #(
    parameter int ROBWIDTH = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FREEZE,
    input  logic                alloc_valid_IN,
    input  logic [5:0]          alloc_writeRegister_IN,
    input  logic                alloc_RegDest_IN,
    input  logic                alloc_is_load_IN,
    output logic [ROBWIDTH-1:0] alloc_ROBPointer_OUT,
    output logic                ROB_full_OUT,
    input  logic                complete_valid_IN,
    input  logic [ROBWIDTH-1:0] ROBPointer_IN,
    input  logic [31:0]         aluresult_IN,
    input  logic                Branch_flag_IN,
    input  logic [31:0]         target_PC_IN,
    input  logic                LS_complete_valid_IN,
    input  logic [ROBWIDTH-1:0] LS_ROBPointer_IN,
    input  logic [31:0]         LS_data_IN,
    output logic [31:0]         fwd_data_1_COM,
    output logic [5:0]          fwd_reg_1_COM,
    output logic                fwd_data_1_COM_flag,
    output logic [31:0]         LS_fwd_data_COM,
    output logic [5:0]          LS_fwd_reg_COM,
    output logic                LS_fwd_data_COM_flag,
    output logic [ROBWIDTH-1:0] commit_ROBPointer_OUT,
    output logic                redirect_OUT,
    output logic [31:0]         redirect_PC_OUT
);

    localparam int DEPTH = 1 << ROBWIDTH;

    logic [ROBWIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROBWIDTH:0]   count_q, count_d;

    logic        valid_q   [DEPTH];
    logic        valid_d   [DEPTH];
    logic        done_q    [DEPTH];
    logic        done_d    [DEPTH];
    logic        is_load_q [DEPTH];
    logic        is_load_d [DEPTH];
    logic        reg_dest_q[DEPTH];
    logic        reg_dest_d[DEPTH];
    logic        branch_q  [DEPTH];
    logic        branch_d  [DEPTH];
    logic [5:0]  wreg_q    [DEPTH];
    logic [5:0]  wreg_d    [DEPTH];
    logic [31:0] value_q   [DEPTH];
    logic [31:0] value_d   [DEPTH];
    logic [31:0] target_q  [DEPTH];
    logic [31:0] target_d  [DEPTH];

    logic [31:0]         fwd_data_q, fwd_data_d, ls_data_q, ls_data_d;
    logic [5:0]          fwd_reg_q, fwd_reg_d, ls_reg_q, ls_reg_d;
    logic                fwd_flag_q, fwd_flag_d, ls_flag_q, ls_flag_d;
    logic [ROBWIDTH-1:0] commit_ptr_q, commit_ptr_d;
    logic                redirect_q, redirect_d;
    logic [31:0]         redirect_pc_q, redirect_pc_d;

    logic full, do_commit, redirect_pending, do_alloc;

    assign full                  = (count_q == (ROBWIDTH+1)'(DEPTH));
    assign ROB_full_OUT          = full;
    assign alloc_ROBPointer_OUT  = tail_q;
    assign fwd_data_1_COM        = fwd_data_q;
    assign fwd_reg_1_COM         = fwd_reg_q;
    assign fwd_data_1_COM_flag   = fwd_flag_q;
    assign LS_fwd_data_COM       = ls_data_q;
    assign LS_fwd_reg_COM        = ls_reg_q;
    assign LS_fwd_data_COM_flag  = ls_flag_q;
    assign commit_ROBPointer_OUT = commit_ptr_q;
    assign redirect_OUT          = redirect_q;
    assign redirect_PC_OUT       = redirect_pc_q;

    // Next-state: completions, allocate at tail, retire at head, flush on a taken branch
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        valid_d       = valid_q;
        done_d        = done_q;
        is_load_d     = is_load_q;
        reg_dest_d    = reg_dest_q;
        branch_d      = branch_q;
        wreg_d        = wreg_q;
        value_d       = value_q;
        target_d      = target_q;
        fwd_data_d    = fwd_data_q;
        fwd_reg_d     = fwd_reg_q;
        fwd_flag_d    = 1'b0;
        ls_data_d     = ls_data_q;
        ls_reg_d      = ls_reg_q;
        ls_flag_d     = 1'b0;
        commit_ptr_d  = commit_ptr_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;

        // Commit looks only at registered done, so a completion needs one edge before it retires
        do_commit        = !FREEZE && valid_q[head_q] && done_q[head_q];
        redirect_pending = do_commit && branch_q[head_q];
        do_alloc         = alloc_valid_IN && !full && !FREEZE && !redirect_pending;

        // LS first so that an EXE write to the same slot takes priority
        if (LS_complete_valid_IN && valid_q[LS_ROBPointer_IN] && is_load_q[LS_ROBPointer_IN]) begin
            done_d[LS_ROBPointer_IN]  = 1'b1;
            value_d[LS_ROBPointer_IN] = LS_data_IN;
        end
        if (complete_valid_IN && valid_q[ROBPointer_IN] && !is_load_q[ROBPointer_IN]) begin
            done_d[ROBPointer_IN]   = 1'b1;
            value_d[ROBPointer_IN]  = aluresult_IN;
            branch_d[ROBPointer_IN] = Branch_flag_IN;
            target_d[ROBPointer_IN] = target_PC_IN;
        end

        if (do_commit) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + ROBWIDTH'(1);
            commit_ptr_d    = head_q;
            if (is_load_q[head_q]) begin
                ls_data_d = value_q[head_q];
                ls_reg_d  = wreg_q[head_q];
                ls_flag_d = reg_dest_q[head_q] && (wreg_q[head_q] != 6'd0);
            end else begin
                fwd_data_d = value_q[head_q];
                fwd_reg_d  = wreg_q[head_q];
                fwd_flag_d = reg_dest_q[head_q] && (wreg_q[head_q] != 6'd0);
            end
        end

        if (do_alloc) begin
            valid_d[tail_q]    = 1'b1;
            done_d[tail_q]     = 1'b0;
            is_load_d[tail_q]  = alloc_is_load_IN;
            reg_dest_d[tail_q] = alloc_RegDest_IN;
            wreg_d[tail_q]     = alloc_writeRegister_IN;
            branch_d[tail_q]   = 1'b0;
            tail_d             = tail_q + ROBWIDTH'(1);
        end

        count_d = count_q + (ROBWIDTH+1)'(do_alloc) - (ROBWIDTH+1)'(do_commit);

        // Taken branch retires alone; everything younger is squashed this edge
        if (redirect_pending) begin
            redirect_d    = 1'b1;
            redirect_pc_d = target_q[head_q];
            tail_d        = head_q + ROBWIDTH'(1);
            count_d       = '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fwd_data_q    <= '0;
            fwd_reg_q     <= '0;
            fwd_flag_q    <= 1'b0;
            ls_data_q     <= '0;
            ls_reg_q      <= '0;
            ls_flag_q     <= 1'b0;
            commit_ptr_q  <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]    <= 1'b0;
                done_q[i]     <= 1'b0;
                is_load_q[i]  <= 1'b0;
                reg_dest_q[i] <= 1'b0;
                branch_q[i]   <= 1'b0;
                wreg_q[i]     <= '0;
                value_q[i]    <= '0;
                target_q[i]   <= '0;
            end
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            fwd_data_q    <= fwd_data_d;
            fwd_reg_q     <= fwd_reg_d;
            fwd_flag_q    <= fwd_flag_d;
            ls_data_q     <= ls_data_d;
            ls_reg_q      <= ls_reg_d;
            ls_flag_q     <= ls_flag_d;
            commit_ptr_q  <= commit_ptr_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            valid_q       <= valid_d;
            done_q        <= done_d;
            is_load_q     <= is_load_d;
            reg_dest_q    <= reg_dest_d;
            branch_q      <= branch_d;
            wreg_q        <= wreg_d;
            value_q       <= value_d;
            target_q      <= target_d;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed self-checking bench for rob_commit
module tb_rob_commit;

    logic        CLK = 1'b0;
    logic        RESET, FREEZE;
    logic        alloc_valid_IN, alloc_RegDest_IN, alloc_is_load_IN;
    logic [5:0]  alloc_writeRegister_IN;
    logic [5:0]  alloc_ROBPointer_OUT;
    logic        ROB_full_OUT;
    logic        complete_valid_IN, Branch_flag_IN;
    logic [5:0]  ROBPointer_IN;
    logic [31:0] aluresult_IN, target_PC_IN;
    logic        LS_complete_valid_IN;
    logic [5:0]  LS_ROBPointer_IN;
    logic [31:0] LS_data_IN;
    logic [31:0] fwd_data_1_COM, LS_fwd_data_COM, redirect_PC_OUT;
    logic [5:0]  fwd_reg_1_COM, LS_fwd_reg_COM, commit_ROBPointer_OUT;
    logic        fwd_data_1_COM_flag, LS_fwd_data_COM_flag, redirect_OUT;

    int n_tests = 0;
    int n_fail  = 0;

    rob_commit #(.ROBWIDTH(6)) dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
        .alloc_valid_IN(alloc_valid_IN), .alloc_writeRegister_IN(alloc_writeRegister_IN),
        .alloc_RegDest_IN(alloc_RegDest_IN), .alloc_is_load_IN(alloc_is_load_IN),
        .alloc_ROBPointer_OUT(alloc_ROBPointer_OUT), .ROB_full_OUT(ROB_full_OUT),
        .complete_valid_IN(complete_valid_IN), .ROBPointer_IN(ROBPointer_IN),
        .aluresult_IN(aluresult_IN), .Branch_flag_IN(Branch_flag_IN), .target_PC_IN(target_PC_IN),
        .LS_complete_valid_IN(LS_complete_valid_IN), .LS_ROBPointer_IN(LS_ROBPointer_IN),
        .LS_data_IN(LS_data_IN),
        .fwd_data_1_COM(fwd_data_1_COM), .fwd_reg_1_COM(fwd_reg_1_COM),
        .fwd_data_1_COM_flag(fwd_data_1_COM_flag),
        .LS_fwd_data_COM(LS_fwd_data_COM), .LS_fwd_reg_COM(LS_fwd_reg_COM),
        .LS_fwd_data_COM_flag(LS_fwd_data_COM_flag),
        .commit_ROBPointer_OUT(commit_ROBPointer_OUT),
        .redirect_OUT(redirect_OUT), .redirect_PC_OUT(redirect_PC_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
    endtask

    task automatic alloc(input logic [5:0] r, input logic rd, input logic ld);
        alloc_valid_IN = 1'b1; alloc_writeRegister_IN = r;
        alloc_RegDest_IN = rd; alloc_is_load_IN = ld;
        tick();
        alloc_valid_IN = 1'b0; alloc_is_load_IN = 1'b0;
    endtask

    task automatic complete(input logic [5:0] t, input logic [31:0] v, input logic br, input logic [31:0] tgt);
        complete_valid_IN = 1'b1; ROBPointer_IN = t; aluresult_IN = v;
        Branch_flag_IN = br; target_PC_IN = tgt;
        tick();
        complete_valid_IN = 1'b0; Branch_flag_IN = 1'b0;
    endtask

    task automatic check_commit(input string tag, input logic [5:0] ptr, input logic [31:0] d, input logic [5:0] r);
        check_eq({tag, "_ptr"},  commit_ROBPointer_OUT, ptr);
        check_eq({tag, "_data"}, fwd_data_1_COM, d);
        check_eq({tag, "_reg"},  fwd_reg_1_COM, r);
        check_eq({tag, "_flag"}, fwd_data_1_COM_flag, 1);
    endtask

    initial begin
        FREEZE = 0; alloc_valid_IN = 0; alloc_writeRegister_IN = 0; alloc_RegDest_IN = 0;
        alloc_is_load_IN = 0; complete_valid_IN = 0; ROBPointer_IN = 0; aluresult_IN = 0;
        Branch_flag_IN = 0; target_PC_IN = 0; LS_complete_valid_IN = 0; LS_ROBPointer_IN = 0;
        LS_data_IN = 0; RESET = 0;
        tick();
        do_reset();
        check_eq("rst_ptr", alloc_ROBPointer_OUT, 0);
        check_eq("rst_full", ROB_full_OUT, 0);
        check_eq("rst_fwd_flag", fwd_data_1_COM_flag, 0);
        check_eq("rst_ls_flag", LS_fwd_data_COM_flag, 0);
        check_eq("rst_redirect", redirect_OUT, 0);
        check_eq("rst_cptr", commit_ROBPointer_OUT, 0);

        // Three ALU ops, completed out of order 2,0,1
        check_eq("tag0", alloc_ROBPointer_OUT, 0); alloc(6'd5, 1, 0);
        check_eq("tag1", alloc_ROBPointer_OUT, 1); alloc(6'd6, 1, 0);
        check_eq("tag2", alloc_ROBPointer_OUT, 2); alloc(6'd7, 1, 0);
        complete(6'd2, 32'h22, 0, 0);
        check_eq("no_commit_early", fwd_data_1_COM_flag, 0);
        complete(6'd0, 32'h00, 0, 0);
        complete(6'd1, 32'h11, 0, 0);
        check_commit("c0", 6'd0, 32'h00, 6'd5);
        tick(); check_commit("c1", 6'd1, 32'h11, 6'd6);
        tick(); check_commit("c2", 6'd2, 32'h22, 6'd7);
        tick(); check_eq("idle_flag", fwd_data_1_COM_flag, 0);

        // Load entry: EXE completion ignored, LS completion retires on the LS bus
        check_eq("tag3", alloc_ROBPointer_OUT, 3); alloc(6'd9, 1, 1);
        complete(6'd3, 32'h55, 0, 0);
        tick();
        check_eq("ld_exe_ign_fwd", fwd_data_1_COM_flag, 0);
        check_eq("ld_exe_ign_ls", LS_fwd_data_COM_flag, 0);
        LS_complete_valid_IN = 1; LS_ROBPointer_IN = 6'd3; LS_data_IN = 32'hDEAD;
        tick();
        LS_complete_valid_IN = 0;
        tick();
        check_eq("ld_data", LS_fwd_data_COM, 32'hDEAD);
        check_eq("ld_reg", LS_fwd_reg_COM, 9);
        check_eq("ld_flag", LS_fwd_data_COM_flag, 1);
        check_eq("ld_fwd_flag", fwd_data_1_COM_flag, 0);
        check_eq("ld_ptr", commit_ROBPointer_OUT, 3);
        check_eq("ld_fwd_keep", fwd_data_1_COM, 32'h22);
        tick(); check_eq("ld_flag_pulse", LS_fwd_data_COM_flag, 0);

        // Fill all 64 entries
        do_reset();
        for (int i = 0; i < 64; i++) alloc(6'((i % 63) + 1), 1, 0);
        check_eq("full", ROB_full_OUT, 1);
        check_eq("full_ptr", alloc_ROBPointer_OUT, 0);
        alloc(6'd33, 1, 0);
        check_eq("full_ign_ptr", alloc_ROBPointer_OUT, 0);
        check_eq("full_ign_full", ROB_full_OUT, 1);
        alloc_valid_IN = 1; alloc_writeRegister_IN = 6'd33; alloc_RegDest_IN = 1;
        complete(6'd0, 32'h77, 0, 0);
        alloc_valid_IN = 1;
        tick();
        check_commit("full_c0", 6'd0, 32'h77, 6'd1);
        check_eq("full_drop", ROB_full_OUT, 0);
        check_eq("full_blk_ptr", alloc_ROBPointer_OUT, 0);
        tick();
        alloc_valid_IN = 0;
        check_eq("wrap_ptr", alloc_ROBPointer_OUT, 1);
        check_eq("wrap_full", ROB_full_OUT, 1);

        // Branch at head with five younger completed entries
        do_reset();
        alloc(6'd0, 0, 0);
        for (int i = 1; i <= 5; i++) alloc(6'd10, 1, 0);
        for (int i = 1; i <= 5; i++) complete(6'(i), 32'(i), 0, 0);
        check_eq("br_wait", fwd_data_1_COM_flag, 0);
        complete(6'd0, 32'h99, 1, 32'h400100);
        alloc_valid_IN = 1; alloc_writeRegister_IN = 6'd11; alloc_RegDest_IN = 1;
        tick();
        alloc_valid_IN = 0;
        check_eq("br_redirect", redirect_OUT, 1);
        check_eq("br_pc", redirect_PC_OUT, 32'h400100);
        check_eq("br_cptr", commit_ROBPointer_OUT, 0);
        check_eq("br_fwd_flag", fwd_data_1_COM_flag, 0);
        check_eq("br_tail", alloc_ROBPointer_OUT, 1);
        check_eq("br_full", ROB_full_OUT, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("br_pulse", redirect_OUT, 0);
            check_eq("br_flushed", fwd_data_1_COM_flag, 0);
        end
        check_eq("br_tail2", alloc_ROBPointer_OUT, 1);

        // FREEZE with a done head
        alloc(6'd12, 1, 0);
        alloc(6'd13, 1, 0);
        complete(6'd1, 32'hAB, 0, 0);
        FREEZE = 1;
        complete(6'd2, 32'hCD, 0, 0);
        check_eq("frz_flag0", fwd_data_1_COM_flag, 0);
        tick(); check_eq("frz_flag1", fwd_data_1_COM_flag, 0);
        tick(); check_eq("frz_flag2", fwd_data_1_COM_flag, 0);
        FREEZE = 0;
        tick(); check_commit("frz_c1", 6'd1, 32'hAB, 6'd12);
        tick(); check_commit("frz_c2", 6'd2, 32'hCD, 6'd13);

        // Reset with 10 entries in flight, some completed
        do_reset();
        for (int i = 0; i < 10; i++) alloc(6'd20, 1, 0);
        for (int i = 1; i <= 5; i++) complete(6'(i), 32'(i), 0, 0);
        do_reset();
        check_eq("rst2_ptr", alloc_ROBPointer_OUT, 0);
        check_eq("rst2_full", ROB_full_OUT, 0);
        check_eq("rst2_fwd_data", fwd_data_1_COM, 0);
        check_eq("rst2_fwd_reg", fwd_reg_1_COM, 0);
        check_eq("rst2_ls_data", LS_fwd_data_COM, 0);
        check_eq("rst2_ls_reg", LS_fwd_reg_COM, 0);
        check_eq("rst2_cptr", commit_ROBPointer_OUT, 0);
        check_eq("rst2_rpc", redirect_PC_OUT, 0);
        complete(6'd0, 32'h123, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst2_old_tag", fwd_data_1_COM_flag, 0);
        end
        check_eq("rst2_ptr_after", alloc_ROBPointer_OUT, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
